// File: rtl/scan_chain_arbiter_pkg.sv
// Shared types for the scan-chain arbiter: FSM state encoding and counter width helper.
package scan_chain_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index strictly after 'last', wrapping.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IW-1:0]      last,
  output logic               any,
  output logic [IW-1:0]      pick_idx,
  output logic [NUM_REQ-1:0] pick_onehot
);

  always_comb begin
    any         = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    // k = NUM_REQ wraps back to 'last' itself, so a lone requester can be re-picked.
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any && eligible[(int'(last) + k) % NUM_REQ]) begin
        any      = 1'b1;
        pick_idx = IW'((int'(last) + k) % NUM_REQ);
      end
    end
    if (any) pick_onehot[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/scan_chain_arbiter.sv
// Round-robin owner of the shared scan chain with watchdog revoke, lockout and an all-low
// guard gap between owners; chain lines are registered copies of the owner's lines.
module scan_chain_arbiter
  import scan_chain_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int GUARD_CYCLES = 4,
  parameter int TO_W         = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         m_scan_clk,
  input  logic [NUM_REQ-1:0]         m_scan_data,
  input  logic [NUM_REQ-1:0]         m_scan_select,
  input  logic [NUM_REQ-1:0]         m_scan_latch_en,
  input  logic [TO_W-1:0]            timeout_cfg,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] owner_idx,
  output logic                       busy,
  output logic                       timeout_evt,
  output logic                       scan_clk_out,
  output logic                       scan_data_out,
  output logic                       scan_select,
  output logic                       scan_latch_en
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = cnt_w(GUARD_CYCLES);
  localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] OWNER_RST  = IW'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic [TO_W-1:0]      cfg_q, cfg_d;
  logic [GW-1:0]        guard_q, guard_d;
  logic [NUM_REQ-1:0]   lockout_q, lockout_d;
  logic                 evt_q, evt_d;
  logic [3:0]           scan_q, scan_d;

  logic [NUM_REQ-1:0]   eligible;
  logic                 pick_any;
  logic [IW-1:0]        pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic                 owner_req;
  logic                 cnt_hit;

  assign eligible = req & ~lockout_q;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .eligible    (eligible),
    .last        (owner_q),
    .any         (pick_any),
    .pick_idx    (pick_idx),
    .pick_onehot (pick_onehot)
  );

  assign owner_req = req[owner_q];
  assign cnt_hit   = (cfg_q != '0) && (cnt_q == cfg_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    cfg_d     = cfg_q;
    guard_d   = guard_q;
    evt_d     = 1'b0;
    scan_d    = '0;
    lockout_d = lockout_q & req;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_OWN;
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          cfg_d   = timeout_cfg;
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        scan_d = {m_scan_clk[owner_q], m_scan_data[owner_q],
                  m_scan_select[owner_q], m_scan_latch_en[owner_q]};
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (!owner_req || cnt_hit) begin
          gnt_d   = '0;
          scan_d  = '0;
          guard_d = '0;
          state_d = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
          // A release on the same edge as the watchdog hit wins: no event, no lockout.
          if (owner_req) begin
            evt_d              = 1'b1;
            lockout_d[owner_q] = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        if (guard_q == GUARD_LAST) state_d = ST_IDLE;
        else                       guard_d = guard_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= OWNER_RST;
      cnt_q     <= '0;
      cfg_q     <= '0;
      guard_q   <= '0;
      lockout_q <= '0;
      evt_q     <= 1'b0;
      scan_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      cfg_q     <= cfg_d;
      guard_q   <= guard_d;
      lockout_q <= lockout_d;
      evt_q     <= evt_d;
      scan_q    <= scan_d;
    end
  end

  assign gnt           = gnt_q;
  assign owner_idx     = owner_q;
  assign busy          = (state_q != ST_IDLE);
  assign timeout_evt   = evt_q;
  assign scan_clk_out  = scan_q[3];
  assign scan_data_out = scan_q[2];
  assign scan_select   = scan_q[1];
  assign scan_latch_en = scan_q[0];

endmodule

// File: tb/tb_scan_chain_arbiter.sv
// Scoreboard bench for scan_chain_arbiter: expected chain lines and grant order are queued as
// stimulus is driven and popped when the arbiter presents them.
module tb_scan_chain_arbiter;

  localparam int NR = 3;
  localparam int G  = 4;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req, msc, msd, mss, msl;
  logic [TW-1:0] cfg;
  logic [NR-1:0] gnt;
  logic [1:0]    owner_idx;
  logic          busy, timeout_evt;
  logic          scan_clk_out, scan_data_out, scan_select, scan_latch_en;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] exp_scan_q[$];
  int         exp_own_q[$];

  scan_chain_arbiter #(.NUM_REQ(NR), .GUARD_CYCLES(G), .TO_W(TW)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .m_scan_clk      (msc),
    .m_scan_data     (msd),
    .m_scan_select   (mss),
    .m_scan_latch_en (msl),
    .timeout_cfg     (cfg),
    .gnt             (gnt),
    .owner_idx       (owner_idx),
    .busy            (busy),
    .timeout_evt     (timeout_evt),
    .scan_clk_out    (scan_clk_out),
    .scan_data_out   (scan_data_out),
    .scan_select     (scan_select),
    .scan_latch_en   (scan_latch_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] scan_now();
    return {scan_clk_out, scan_data_out, scan_select, scan_latch_en};
  endfunction

  task automatic do_reset();
    #2 reset = 1'b1;
    req = '0; msc = '0; msd = '0; mss = '0; msl = '0; cfg = '0;
    tick();
    tick();
    #2 reset = 1'b0;
  endtask

  // Drive random lines on every master (master 2 optionally toggling all lines each cycle),
  // queue the owner's lines, and expect them on the chain one cycle later.
  task automatic scan_run(input int o, input int n, input bit toggle2);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      msc = NR'($urandom); msd = NR'($urandom); mss = NR'($urandom); msl = NR'($urandom);
      if (toggle2) begin
        msc[2] = i[0]; msd[2] = i[0]; mss[2] = i[0]; msl[2] = i[0];
      end
      exp_scan_q.push_back({msc[o], msd[o], mss[o], msl[o]});
      tick();
      e = exp_scan_q.pop_front();
      check("scan_mirror", 32'(scan_now()), 32'(e));
      check("gnt_hold", 32'(gnt), 32'(1 << o));
    end
  endtask

  initial begin
    int w, hi, evts, o;
    reset = 1'b1;
    req = '0; msc = '0; msd = '0; mss = '0; msl = '0; cfg = '0;
    #2;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_owner", 32'(owner_idx), 32'd2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_evt", 32'(timeout_evt), 32'd0);
    check("rst_scan", 32'(scan_now()), 32'd0);
    tick();
    #2 reset = 1'b0;
    tick();

    // 1: single master 1, mirror, release and guard gap
    req = 3'b010; msc = '1; msd = '1; mss = '1; msl = '1;
    tick();
    check("t1_gnt", 32'(gnt), 32'b010);
    check("t1_owner", 32'(owner_idx), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_scan_first", 32'(scan_now()), 32'd0);
    scan_run(1, 6, 1'b0);
    req = 3'b000; msc = '1; msd = '1; mss = '1; msl = '1;
    tick();
    check("t1_rel_gnt", 32'(gnt), 32'd0);
    check("t1_rel_scan", 32'(scan_now()), 32'd0);
    for (int i = 0; i < G; i++) begin
      tick();
      check("t1_guard_scan", 32'(scan_now()), 32'd0);
      check("t1_guard_busy", 32'(busy), (i < G - 1) ? 32'd1 : 32'd0);
    end

    // 2: all request, round-robin order and grant-to-grant gap
    do_reset();
    exp_own_q = '{0, 1, 2, 0};
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (gnt == '0 && w < 20) begin
        tick();
        w++;
      end
      if (k > 0) check("t2_gap", 32'(w), 32'd5);
      o = exp_own_q.pop_front();
      check("t2_order", 32'(gnt), 32'(1 << o));
      check("t2_owner", 32'(owner_idx), 32'(o));
      for (int c = 0; c < 9; c++) begin
        tick();
        check("t2_onehot", 32'($onehot(gnt)), 32'd1);
      end
      req[o] = 1'b0;
      tick();
      check("t2_rel", 32'(gnt), 32'd0);
      req[o] = 1'b1;
    end

    // 3: watchdog revoke, lockout until req drops
    do_reset();
    cfg = 16'd20;
    req = 3'b100;
    tick();
    check("t3_gnt", 32'(gnt), 32'b100);
    hi = 1;
    for (int i = 0; i < 100 && gnt[2]; i++) begin
      tick();
      if (gnt[2]) hi++;
    end
    check("t3_len", 32'(hi), 32'd20);
    check("t3_evt", 32'(timeout_evt), 32'd1);
    evts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      evts += int'(timeout_evt);
      if (gnt != '0) evts += 100;
    end
    check("t3_locked", 32'(evts), 32'd0);
    req = 3'b000;
    tick();
    req = 3'b100;
    tick();
    check("t3_regrant", 32'(gnt), 32'b100);

    // 5: release on the same edge as the watchdog hit
    do_reset();
    cfg = 16'd8;
    req = 3'b001;
    tick();
    check("t5_gnt", 32'(gnt), 32'b001);
    for (int i = 0; i < 7; i++) tick();
    check("t5_still", 32'(gnt), 32'b001);
    req = 3'b000;
    tick();
    check("t5_rel", 32'(gnt), 32'd0);
    evts = int'(timeout_evt);
    for (int i = 0; i < G; i++) begin
      tick();
      evts += int'(timeout_evt);
    end
    check("t5_no_evt", 32'(evts), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    req = 3'b001;
    tick();
    check("t5_regrant", 32'(gnt), 32'b001);

    // 6: owner 0 while master 2 toggles
    do_reset();
    req = 3'b001;
    tick();
    check("t6_gnt", 32'(gnt), 32'b001);
    scan_run(0, 12, 1'b1);

    // 4: async reset mid-ownership
    msc = 3'b001; msd = '0; mss = '0; msl = '0;
    tick();
    check("t4_pre_clk", 32'(scan_clk_out), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t4_clk", 32'(scan_clk_out), 32'd0);
    check("t4_gnt", 32'(gnt), 32'd0);
    check("t4_owner", 32'(owner_idx), 32'd2);
    req = 3'b101;
    #2 reset = 1'b0;
    tick();
    check("t4_first", 32'(gnt), 32'b001);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
